// File: rtl/deserializer.sv
// deserializer: collects an MSB-first valid-qualified bit stream into left-aligned words,
// flushing partial words after an idle gap, with a single-register valid/ready output.
module deserializer #(
   parameter int DATA_W       = 16,
   parameter int DATA_MOD_W   = 4,
   parameter int IDLE_TIMEOUT = 4
) (
   input  logic                  clk_i,
   input  logic                  srst_n_i,
   input  logic                  ser_data_i,
   input  logic                  ser_data_val_i,
   output logic [DATA_W-1:0]     deser_data_o,
   output logic [DATA_MOD_W-1:0] deser_mod_o,
   output logic                  deser_data_val_o,
   input  logic                  deser_data_ready_i,
   output logic                  overflow_o
);
   localparam int CNT_W = DATA_MOD_W + 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
   localparam logic [7:0] IDLE_LAST = 8'(IDLE_TIMEOUT - 1);
   localparam logic [7:0] IDLE_MAX = 8'(IDLE_TIMEOUT);

   logic [DATA_W-1:0]     shift_q, shift_d, shift_w;
   logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
   logic [7:0]            idle_cnt_q, idle_cnt_d;
   logic [DATA_W-1:0]     data_q, data_d;
   logic [DATA_MOD_W-1:0] mod_q, mod_d;
   logic                  val_q, val_d;
   logic                  ovf_q, ovf_d;
   logic                  full_done, to_done, done, free;

   always_comb begin
      shift_w = shift_q;
      // DATA_W is a power of two, so DATA_W-1-bit_cnt is the bitwise complement
      if (ser_data_val_i) shift_w[~bit_cnt_q[DATA_MOD_W-1:0]] = ser_data_i;
      full_done  = ser_data_val_i && bit_cnt_q == LAST_BIT;
      to_done    = !ser_data_val_i && bit_cnt_q != '0 && idle_cnt_q == IDLE_LAST;
      done       = full_done || to_done;
      free       = !val_q || deser_data_ready_i;
      shift_d    = done ? '0 : shift_w;
      bit_cnt_d  = done ? '0 : bit_cnt_q + CNT_W'(ser_data_val_i);
      idle_cnt_d = (done || ser_data_val_i || bit_cnt_q == '0) ? '0 :
                   (idle_cnt_q == IDLE_MAX) ? idle_cnt_q : idle_cnt_q + 8'd1;
      data_d     = (done && free) ? shift_w : data_q;
      mod_d      = (done && free) ? (full_done ? '0 : bit_cnt_q[DATA_MOD_W-1:0]) : mod_q;
      val_d      = (done && free) || (val_q && !deser_data_ready_i);
      ovf_d      = done && !free;
   end

   always_ff @(posedge clk_i) begin
      if (!srst_n_i) begin
         shift_q    <= '0;
         bit_cnt_q  <= '0;
         idle_cnt_q <= '0;
         data_q     <= '0;
         mod_q      <= '0;
         val_q      <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         shift_q    <= shift_d;
         bit_cnt_q  <= bit_cnt_d;
         idle_cnt_q <= idle_cnt_d;
         data_q     <= data_d;
         mod_q      <= mod_d;
         val_q      <= val_d;
         ovf_q      <= ovf_d;
      end
   end

   assign deser_data_o     = data_q;
   assign deser_mod_o      = mod_q;
   assign deser_data_val_o = val_q;
   assign overflow_o       = ovf_q;
endmodule

// File: tb/tb_deserializer.sv
// tb_deserializer: directed word table plus hand-written backpressure, gap and reset sequences.
module tb_deserializer;
   logic        clk = 1'b0;
   logic        srst_n = 1'b0;
   logic        ser = 1'b0;
   logic        ser_val = 1'b0;
   logic        ready = 1'b1;
   logic [15:0] data;
   logic [3:0]  mod;
   logic        dval;
   logic        ovf;
   int          total = 0;
   int          bad = 0;

   deserializer #(.DATA_W(16), .DATA_MOD_W(4), .IDLE_TIMEOUT(4)) dut (
      .clk_i(clk), .srst_n_i(srst_n), .ser_data_i(ser), .ser_data_val_i(ser_val),
      .deser_data_o(data), .deser_mod_o(mod), .deser_data_val_o(dval),
      .deser_data_ready_i(ready), .overflow_o(ovf)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] word;
      int          nbits;
      logic [15:0] exp_data;
      logic [3:0]  exp_mod;
      int          exp_wait;
   } vec_t;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", name, act, exp);
      end
   endtask

   task automatic send(input logic [15:0] w, input int n);
      for (int i = 0; i < n; i++) begin
         ser = w[15-i];
         ser_val = 1'b1;
         tick();
      end
      ser_val = 1'b0;
      ser = 1'b0;
   endtask

   initial begin
      vec_t vecs[6];
      #200000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs[6];
      vecs[0] = '{16'hA5C3, 16, 16'hA5C3, 4'd0, 0};
      vecs[1] = '{16'hB000, 5, 16'hB000, 4'd5, 4};
      vecs[2] = '{16'hFFFF, 16, 16'hFFFF, 4'd0, 0};
      vecs[3] = '{16'h8000, 1, 16'h8000, 4'd1, 4};
      vecs[4] = '{16'h0000, 16, 16'h0000, 4'd0, 0};
      vecs[5] = '{16'hFFFE, 15, 16'hFFFE, 4'd15, 4};

      tick();
      tick();
      chk("rst_data", data, 0);
      chk("rst_mod", mod, 0);
      chk("rst_val", dval, 0);
      chk("rst_ovf", ovf, 0);
      srst_n = 1'b1;

      for (int v = 0; v < 6; v++) begin
         send(vecs[v].word, vecs[v].nbits);
         for (int k = 0; k < vecs[v].exp_wait; k++) begin
            chk($sformatf("v%0d_early_val", v), dval, 0);
            tick();
         end
         chk($sformatf("v%0d_val", v), dval, 1);
         chk($sformatf("v%0d_data", v), data, vecs[v].exp_data);
         chk($sformatf("v%0d_mod", v), mod, vecs[v].exp_mod);
         tick();
         chk($sformatf("v%0d_val_drop", v), dval, 0);
      end

      // short gap: 3 bits, 3 idle cycles, 13 bits -> one full word
      send(16'hE00F, 3);
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("gap_no_flush", dval, 0);
      end
      send(16'h00F << 3, 13);
      chk("gap_val", dval, 1);
      chk("gap_data", data, 16'hE00F);
      chk("gap_mod", mod, 0);
      tick();

      // backpressure: second word dropped, first held
      ready = 1'b0;
      send(16'h1234, 16);
      chk("bp_val1", dval, 1);
      chk("bp_data1", data, 16'h1234);
      send(16'hFFFF, 16);
      chk("bp_ovf", ovf, 1);
      chk("bp_hold", data, 16'h1234);
      chk("bp_hold_mod", mod, 0);
      tick();
      chk("bp_ovf_pulse", ovf, 0);
      chk("bp_val_held", dval, 1);
      ready = 1'b1;
      tick();
      chk("bp_accept_val", dval, 0);
      chk("bp_keep_data", data, 16'h1234);

      // accept and completion on the same edge
      ready = 1'b0;
      send(16'h1234, 16);
      send(16'hABCD, 15);
      chk("sim_pending", data, 16'h1234);
      ready = 1'b1;
      ser = 1'b1;
      ser_val = 1'b1;
      tick();
      ser_val = 1'b0;
      ready = 1'b0;
      chk("sim_val", dval, 1);
      chk("sim_data", data, 16'hABCD);
      chk("sim_ovf", ovf, 0);
      tick();
      chk("sim_ovf_after", ovf, 0);
      ready = 1'b1;
      tick();

      // reset with a pending word and a partial word
      ready = 1'b0;
      send(16'h5555, 16);
      send(16'hFFFF, 7);
      srst_n = 1'b0;
      tick();
      chk("mrst_data", data, 0);
      chk("mrst_mod", mod, 0);
      chk("mrst_val", dval, 0);
      chk("mrst_ovf", ovf, 0);
      srst_n = 1'b1;
      ready = 1'b1;
      send(16'h00FF, 15);
      chk("mrst_no_early", dval, 0);
      send(16'h0001, 16'd0 + 0);
      ser = 1'b1;
      ser_val = 1'b1;
      tick();
      ser_val = 1'b0;
      chk("mrst_val2", dval, 1);
      chk("mrst_data2", data, 16'h00FF);
      chk("mrst_mod2", mod, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
